// File: rtl/bmf_approx_lut_pipe.sv
// bmf_approx_lut_pipe: runtime-programmable Boolean-matrix-factorisation approximate-logic unit.
//
// A compressor maps N_IN partition inputs onto K latent bits, using one loadable truth-table LUT
// per latent bit (W_i, 2**N_IN entries each). A decompressor then maps the K latent bits onto
// M_OUT outputs through a loadable M_OUT x K Boolean matrix H:
//   out_data[j] = OR_i (k[i] & H[j][i])
// Two registered stages with valid/ready flow control. Tables are written through a small
// configuration port that only accepts writes while the pipeline is empty.
//
// Optional feature (macro BMF_XOR_MODE_EN): adds a 1-bit mode register, written through
// cfg_tgt == K with cfg_addr all-ones (cfg_wdata[0]). With mode = 1 the expansion uses XOR
// (GF(2) factorisation) instead of OR. Without the macro only OR is built.
//
// Ports:
//   clk        single clock
//   rst        synchronous reset, active-high; clears tables and drops in-flight words
//   in_valid   input word valid
//   in_ready   unit accepts input this cycle
//   in_data    partition inputs (bit 0 = pi0)
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   approximate outputs (bit j = po_j), registered
//   cfg_we     configuration write strobe
//   cfg_tgt    0..K-1 selects LUT W_i, K selects an H row
//   cfg_addr   LUT entry index, or H row index
//   cfg_wdata  LUT write uses bit 0, H row write uses all K bits
//   cfg_ready  write accepted this cycle (pipeline empty)
module bmf_approx_lut_pipe #(
  parameter int N_IN   = 6,
  parameter int K      = 3,
  parameter int M_OUT  = 4,
  parameter int TGT_W  = $clog2(K + 1),
  parameter int ADDR_W = (N_IN > $clog2(M_OUT)) ? N_IN : $clog2(M_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M_OUT-1:0]  out_data,
  input  logic              cfg_we,
  input  logic [TGT_W-1:0]  cfg_tgt,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [K-1:0]      cfg_wdata,
  output logic              cfg_ready
);

  localparam int                DEPTH     = 2 ** N_IN;
  localparam logic [TGT_W-1:0]  TGT_H     = TGT_W'(K);
  localparam logic [ADDR_W-1:0] ADDR_ONES = '1;

  // Packed tables so reset and per-bit writes stay plain vector operations.
  logic [K-1:0][DEPTH-1:0] w_lut;
  logic [M_OUT-1:0][K-1:0] h_mat;

  logic              s1_valid;
  logic [K-1:0]      s1_k;
  logic [K-1:0]      k_lookup;
  logic [M_OUT-1:0]  expand;
  logic              accept;
  logic              s2_open;
  logic              cfg_fire;

`ifdef BMF_XOR_MODE_EN
  logic              xor_mode;
`endif

  // Stage 2 can take a new word when empty or when its current word leaves this cycle.
  assign s2_open   = ~out_valid | out_ready;
  // Config strobe blocks input so a write never races an accept.
  assign in_ready  = ~rst & ~cfg_we & (~s1_valid | ~out_valid | out_ready);
  assign cfg_ready = ~rst & ~s1_valid & ~out_valid;
  assign accept    = in_valid & in_ready;
  assign cfg_fire  = cfg_we & cfg_ready;

  always_comb begin
    k_lookup = '0;
    for (int i = 0; i < K; i++) begin
      k_lookup[i] = w_lut[i][in_data];
    end
  end

  always_comb begin
    expand = '0;
    for (int j = 0; j < M_OUT; j++) begin
      for (int i = 0; i < K; i++) begin
`ifdef BMF_XOR_MODE_EN
        if (xor_mode) begin
          expand[j] = expand[j] ^ (s1_k[i] & h_mat[j][i]);
        end else begin
          expand[j] = expand[j] | (s1_k[i] & h_mat[j][i]);
        end
`else
        expand[j] = expand[j] | (s1_k[i] & h_mat[j][i]);
`endif
      end
    end
  end

  // Configuration tables.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_lut <= '0;
      h_mat <= '0;
`ifdef BMF_XOR_MODE_EN
      xor_mode <= 1'b0;
`endif
    end else if (cfg_fire) begin
      for (int i = 0; i < K; i++) begin
        if (cfg_tgt == TGT_W'(i)) begin
          w_lut[i][cfg_addr[N_IN-1:0]] <= cfg_wdata[0];
        end
      end
`ifdef BMF_XOR_MODE_EN
      if (cfg_tgt == TGT_H && cfg_addr == ADDR_ONES) begin
        xor_mode <= cfg_wdata[0];
      end else
`endif
      if (cfg_tgt == TGT_H) begin
        // Rows at or beyond M_OUT match no j and are dropped.
        for (int j = 0; j < M_OUT; j++) begin
          if ({1'b0, cfg_addr} == (ADDR_W + 1)'(j)) begin
            h_mat[j] <= cfg_wdata;
          end
        end
      end
    end
  end

  // Pipeline stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_k      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_k     <= k_lookup;
      end else if (s2_open) begin
        s1_valid <= 1'b0;
      end
      if (s2_open) begin
        out_valid <= s1_valid;
        // out_data only changes when a real word moves in; it holds across bubbles.
        if (s1_valid) begin
          out_data <= expand;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmf_approx_lut_pipe.sv
// Testbench for bmf_approx_lut_pipe: directed steps with a scoreboard of expected outputs built
// from a small behavioural model of the LUTs and H matrix.
module tb_bmf_approx_lut_pipe;

  localparam int N_IN  = 6;
  localparam int K     = 3;
  localparam int M_OUT = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [M_OUT-1:0] out_data;
  logic             cfg_we;
  logic [1:0]       cfg_tgt;
  logic [5:0]       cfg_addr;
  logic [K-1:0]     cfg_wdata;
  logic             cfg_ready;

  bmf_approx_lut_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_tgt   (cfg_tgt),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int popped      = 0;

  logic [63:0]      w_m [K];
  logic [K-1:0]     h_m [M_OUT];
  logic             mode_m;
  logic [M_OUT-1:0] q[$];
  logic [5:0]       stream_d [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [M_OUT-1:0] model(input logic [5:0] d);
    logic [K-1:0]     k;
    logic [M_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < K; i++) k[i] = w_m[i][d];
    for (int j = 0; j < M_OUT; j++) begin
      for (int i = 0; i < K; i++) begin
        if (mode_m) r[j] = r[j] ^ (k[i] & h_m[j][i]);
        else        r[j] = r[j] | (k[i] & h_m[j][i]);
      end
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < K; i++) w_m[i] = '0;
    for (int j = 0; j < M_OUT; j++) h_m[j] = '0;
    mode_m = 1'b0;
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(posedge clk) begin
    if (in_valid === 1'b1 && in_ready === 1'b1) q.push_back(model(in_data));
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty", (q.size() > 0), 1);
      if (q.size() > 0) chk("sb_data", out_data, q.pop_front());
      popped++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] tgt, input logic [5:0] addr, input logic [K-1:0] d);
    cfg_we = 1'b1; cfg_tgt = tgt; cfg_addr = addr; cfg_wdata = d;
    #1;
    chk("cfg_ready_idle", cfg_ready, 1);
    chk("cfg_in_ready_low", in_ready, 0);
    tick();
    cfg_we = 1'b0;
    if (tgt < 2'(K)) w_m[tgt][addr] = d[0];
    else if (tgt == 2'(K)) begin
`ifdef BMF_XOR_MODE_EN
      if (addr == 6'h3F) mode_m = d[0];
      else
`endif
      if (addr < 6'(M_OUT)) h_m[addr[1:0]] = d;
    end
  endtask

  // One isolated word: checks acceptance, 2-cycle latency and the hand-computed result.
  task automatic send(input logic [5:0] d, input logic [M_OUT-1:0] exp);
    in_valid = 1'b1; in_data = d;
    #1;
    chk("send_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("lat1_out_valid", out_valid, 0);
    tick();
    chk("lat2_out_valid", out_valid, 1);
    chk("lat2_out_data", out_data, exp);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid !== 1'b0) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_done", (q.size() == 0 && out_valid === 1'b0), 1);
  endtask

  initial begin
    int  sent;
    int  base;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_tgt = '0; cfg_addr = '0; cfg_wdata = '0;
    model_clear();
    stream_d = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h3F, 6'h08, 6'h02, 6'h01};
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_out_valid", out_valid, 0);
    tick();

    // Basic OR expansion.
    cfg_wr(2'd3, 6'd0, 3'b001);
    cfg_wr(2'd3, 6'd1, 3'b000);
    cfg_wr(2'd3, 6'd2, 3'b010);
    cfg_wr(2'd3, 6'd3, 3'b100);
    cfg_wr(2'd1, 6'h01, 3'b001);
    send(6'h01, 4'b0100);
    send(6'h00, 4'b0000);

    cfg_wr(2'd0, 6'h3F, 3'b001);
    cfg_wr(2'd1, 6'h3F, 3'b001);
    cfg_wr(2'd3, 6'd0, 3'b011);
    send(6'h3F, 4'b0101);
`ifdef BMF_XOR_MODE_EN
    cfg_wr(2'd3, 6'h3F, 3'b001);
    send(6'h3F, 4'b0100);
    cfg_wr(2'd3, 6'h3F, 3'b000);
`else
    // H row beyond M_OUT: dropped, result unchanged.
    cfg_wr(2'd3, 6'h3F, 3'b111);
    send(6'h3F, 4'b0101);
`endif
    cfg_wr(2'd3, 6'd4, 3'b111);
    send(6'h3F, 4'b0101);

    // Streaming with a 3-cycle downstream stall.
    cfg_wr(2'd2, 6'h02, 3'b001);
    cfg_wr(2'd0, 6'h04, 3'b001);
    sent = 0;
    base = popped;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      in_data   = (sent < 8) ? stream_d[sent] : 6'h00;
      #1;
      if (c >= 3 && c <= 5) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        if (q.size() > 0) chk("stall_hold", out_data, q[0]);
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      if (sent == 8 && q.size() == 0) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", sent, 8);
    chk("stream_popped", popped - base, 8);
    drain();

    // Config collides with traffic while busy: ignored, input blocked.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 6'h01;
    #1;
    chk("busy_accept", in_ready, 1);
    tick();
    in_data = 6'h02;
    cfg_we = 1'b1; cfg_tgt = 2'd0; cfg_addr = 6'h08; cfg_wdata = 3'b001;
    #1;
    chk("busy_cfg_ready", cfg_ready, 0);
    chk("busy_in_ready", in_ready, 0);
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("busy_out_valid", out_valid, 1);
    out_ready = 1'b1;
    drain();
    send(6'h08, 4'b0000);
    cfg_wr(2'd0, 6'h08, 3'b001);
    send(6'h08, 4'b0001);

    // Reset with two words in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 6'h01;
    #1;
    tick();
    in_data = 6'h3F;
    #1;
    tick();
    in_valid = 1'b0;
    chk("full_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready, 0);
    chk("rst2_cfg_ready", cfg_ready, 0);
    tick();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data", out_data, 0);
    q.delete();
    model_clear();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    send(6'h01, 4'b0000);
    send(6'h3F, 4'b0000);
    send(6'h08, 4'b0000);
    send(6'h04, 4'b0000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
